ci_access_scheduler: RTL and testbench



---
 rtl/ci_access_scheduler.sv | 170 +++++++++++++++++
 tb/tb_ci_access_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ci_access_scheduler.sv
// Two-master round-robin scheduler for CI card accesses: SETUP, STROBE (wait-extended), HOLD.
// Define CI_ACC_TIMEOUT_EN to bound the strobe at TIMEOUT cycles and flag err.
module ci_access_scheduler #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic        m0_io,
  input  logic [14:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic        m1_io,
  input  logic [14:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        busy,
  output logic [7:0]  ci_a,
  output logic [6:0]  ci_a_ext,
  input  logic [7:0]  ci_d_in,
  output logic [7:0]  ci_d_out,
  output logic        ci_d_oe,
  output logic        ci_reg_n,
  output logic        ci_ce1_n,
  output logic        ci_oe_n,
  output logic        ci_we_n,
  output logic        ci_iord_n,
  output logic        ci_iowr_n,
  input  logic        ci_wait_n
);

  localparam int CNT_MAX = (TIMEOUT > 15) ? TIMEOUT : 15;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wait_s1, wait_s2;
  logic          sel_m1, prio_m1, l_wr, l_io, err_q;
  logic          grant_m1, strobe_end, timed_out;

  always_comb begin
    grant_m1   = m1_req && (!m0_req || prio_m1);
    strobe_end = (cnt >= CW'(T_STROBE - 1)) && wait_s2;
    timed_out  = 1'b0;
`ifdef CI_ACC_TIMEOUT_EN
    // A wait release on the very last allowed cycle still counts as a clean finish.
    timed_out  = !strobe_end && (cnt == CW'(TIMEOUT - 1));
`endif
  end

  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_s1 <= 1'b1;
      wait_s2 <= 1'b1;
    end else begin
      wait_s1 <= ci_wait_n;
      wait_s2 <= wait_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_m1    <= 1'b0;
      prio_m1   <= 1'b0;
      l_wr      <= 1'b0;
      l_io      <= 1'b0;
      err_q     <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      rdata     <= 8'h00;
      busy      <= 1'b0;
      ci_a      <= 8'h00;
      ci_a_ext  <= 7'h00;
      ci_d_out  <= 8'h00;
      ci_d_oe   <= 1'b0;
      ci_reg_n  <= 1'b1;
      ci_ce1_n  <= 1'b1;
      ci_oe_n   <= 1'b1;
      ci_we_n   <= 1'b1;
      ci_iord_n <= 1'b1;
      ci_iowr_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            sel_m1   <= grant_m1;
            prio_m1  <= !grant_m1;
            l_wr     <= grant_m1 ? m1_wr : m0_wr;
            l_io     <= grant_m1 ? m1_io : m0_io;
            ci_a     <= grant_m1 ? m1_addr[7:0]  : m0_addr[7:0];
            ci_a_ext <= grant_m1 ? m1_addr[14:8] : m0_addr[14:8];
            ci_d_out <= grant_m1 ? m1_wdata : m0_wdata;
            ci_d_oe  <= grant_m1 ? m1_wr : m0_wr;
            ci_reg_n <= 1'b0;
            ci_ce1_n <= 1'b0;
            busy     <= 1'b1;
            err_q    <= 1'b0;
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CW'(T_SETUP - 1)) begin
            cnt       <= '0;
            state     <= STROBE;
            ci_oe_n   <= l_io || l_wr;
            ci_we_n   <= l_io || !l_wr;
            ci_iord_n <= !l_io || l_wr;
            ci_iowr_n <= !l_io || !l_wr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STROBE: begin
          if (strobe_end || timed_out) begin
            ci_oe_n   <= 1'b1;
            ci_we_n   <= 1'b1;
            ci_iord_n <= 1'b1;
            ci_iowr_n <= 1'b1;
            if (timed_out) rdata <= 8'h00;
            else if (!l_wr) rdata <= ci_d_in;
            err_q <= timed_out;
            cnt   <= '0;
            state <= HOLD;
            if (T_HOLD == 1) begin
              m0_done <= !sel_m1;
              m1_done <= sel_m1;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == CW'(T_HOLD - 1)) begin
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            ci_reg_n <= 1'b1;
            ci_ce1_n <= 1'b1;
            ci_d_oe  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            // done is registered, so raise it one edge ahead of the final HOLD cycle
            if (cnt == CW'(T_HOLD - 2)) begin
              m0_done <= !sel_m1;
              m1_done <= sel_m1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ci_access_scheduler.sv
// Self-checking bench for ci_access_scheduler: per-cycle pin checks against a timing model
// derived from the setup/strobe/hold rules, plus reset, wait, round-robin and random accesses.
module tb_ci_access_scheduler;

  localparam int T_SETUP  = 2;
  localparam int T_STROBE = 4;
  localparam int T_HOLD   = 2;
  localparam int TIMEOUT  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m0_io = 1'b0;
  logic [14:0] m0_addr = '0;
  logic [7:0]  m0_wdata = '0;
  logic        m1_req = 1'b0, m1_wr = 1'b0, m1_io = 1'b0;
  logic [14:0] m1_addr = '0;
  logic [7:0]  m1_wdata = '0;
  logic        m0_done, m1_done, err, busy, ci_d_oe;
  logic [7:0]  rdata, ci_a, ci_d_out;
  logic [6:0]  ci_a_ext;
  logic [7:0]  ci_d_in = '0;
  logic        ci_reg_n, ci_ce1_n, ci_oe_n, ci_we_n, ci_iord_n, ci_iowr_n;
  logic        ci_wait_n = 1'b1;

  logic [3:0]  stb;
  assign stb = {ci_oe_n, ci_we_n, ci_iord_n, ci_iowr_n};

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rdata = 8'h00;

  always #5 clk = ~clk;

  ci_access_scheduler #(
    .T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_HOLD(T_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_io(m0_io), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_done(m0_done),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_io(m1_io), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_done(m1_done),
    .rdata(rdata), .err(err), .busy(busy),
    .ci_a(ci_a), .ci_a_ext(ci_a_ext), .ci_d_in(ci_d_in), .ci_d_out(ci_d_out),
    .ci_d_oe(ci_d_oe), .ci_reg_n(ci_reg_n), .ci_ce1_n(ci_ce1_n), .ci_oe_n(ci_oe_n),
    .ci_we_n(ci_we_n), .ci_iord_n(ci_iord_n), .ci_iowr_n(ci_iowr_n),
    .ci_wait_n(ci_wait_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait level sampled at the edge closing strobe cycle j (negative j = setup cycles).
  function automatic bit wait_at(input int j, input int ws, input int wl);
    return !(j >= ws && j < ws + wl);
  endfunction

  // One single-master access, checked cycle by cycle from the first SETUP cycle.
  task automatic do_access(input bit m, input bit wr, input bit io, input logic [14:0] addr,
                           input logic [7:0] wd, input logic [7:0] din, input int ws, input int wl);
    int slen, total;
    bit to;
    logic [3:0] exp_stb;
    slen = 0;
    to   = 1'b0;
    // Strobe cycle i is last once i >= T_STROBE-1 and the synchronised wait (2 edges old) is high.
    for (int i = T_STROBE - 1; i < 4096 && slen == 0; i++) begin
      if (wait_at(i - 2, ws, wl)) slen = i + 1;
`ifdef CI_ACC_TIMEOUT_EN
      else if (i == TIMEOUT - 1) begin slen = i + 1; to = 1'b1; end
`endif
    end
    total = T_SETUP + slen + T_HOLD;
    if (m) begin m1_req = 1'b1; m1_wr = wr; m1_io = io; m1_addr = addr; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_wr = wr; m0_io = io; m0_addr = addr; m0_wdata = wd; end
    ci_d_in = din;
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      // Changes after the grant must not disturb the access in flight.
      if (m) begin m1_wr = 1'($urandom); m1_io = 1'($urandom); m1_addr = 15'($urandom); m1_wdata = 8'($urandom); end
      else   begin m0_wr = 1'($urandom); m0_io = 1'($urandom); m0_addr = 15'($urandom); m0_wdata = 8'($urandom); end
      exp_stb = 4'hF;
      if (c >= T_SETUP && c < T_SETUP + slen) begin
        case ({io, wr})
          2'b00:   exp_stb = 4'b0111;
          2'b01:   exp_stb = 4'b1011;
          2'b10:   exp_stb = 4'b1101;
          default: exp_stb = 4'b1110;
        endcase
      end
      if (c < total) begin
        chk("acc_busy", busy, 1'b1);
        chk("acc_ce1_reg", {ci_ce1_n, ci_reg_n}, 2'b00);
        chk("acc_d_oe", ci_d_oe, wr);
        chk("acc_strobes", stb, exp_stb);
        chk("acc_addr", {ci_a_ext, ci_a}, addr);
        if (wr) chk("acc_d_out", ci_d_out, wd);
        chk("acc_done", {m1_done, m0_done}, (c == total - 1) ? (m ? 2'b10 : 2'b01) : 2'b00);
        if (c == total - 1) begin
          if (to) exp_rdata = 8'h00;
          else if (!wr) exp_rdata = din;
          chk("acc_rdata", rdata, exp_rdata);
          chk("acc_err", err, to);
          if (m) m1_req = 1'b0; else m0_req = 1'b0;
        end
      end else begin
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", {m1_done, m0_done}, 2'b00);
        chk("idle_pins", {ci_ce1_n, ci_reg_n, stb, ci_d_oe}, 7'b1111110);
        chk("idle_addr_hold", {ci_a_ext, ci_a}, addr);
      end
      ci_wait_n = wait_at(c - T_SETUP, ws, wl);
    end
    ci_wait_n = 1'b1;
  endtask

  initial begin
    int ndone;
    bit idle_seen, exp_m1, prio;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", {m1_done, m0_done}, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_addr", {ci_a_ext, ci_a}, 15'h0000);
    chk("rst_d_out", ci_d_out, 8'h00);
    chk("rst_pins", {ci_ce1_n, ci_reg_n, stb, ci_d_oe}, 7'b1111110);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 8'h1D, 0, 0);
    do_access(1'b1, 1'b1, 1'b1, 15'h0001, 8'hA5, 8'h5A, 0, 0);
    do_access(1'b0, 1'b0, 1'b0, 15'h1234, 8'h00, 8'hC3, 1, 10);
`ifdef CI_ACC_TIMEOUT_EN
    do_access(1'b0, 1'b0, 1'b1, 15'h0042, 8'h00, 8'h77, 0, 100000);
`endif
    for (int n = 0; n < 20; n++)
      do_access(1'($urandom), 1'($urandom), 1'($urandom), 15'($urandom), 8'($urandom),
                8'($urandom), $urandom_range(0, T_STROBE - 3), $urandom_range(0, 12));

    // Reset in the middle of a strobe abandons the access.
    m1_req = 1'b1; m1_wr = 1'b0; m1_io = 1'b0; m1_addr = 15'h2A5C; ci_d_in = 8'h3C;
    repeat (T_SETUP + 2) @(negedge clk);
    chk("pre_rst_oe", ci_oe_n, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_rdata = 8'h00;
    chk("mid_rst_pins", {ci_ce1_n, ci_reg_n, stb, ci_d_oe}, 7'b1111110);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", {m1_done, m0_done}, 2'b00);
    chk("mid_rst_rdata", rdata, exp_rdata);
    chk("mid_rst_addr", {ci_a_ext, ci_a}, 15'h0000);
    m1_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_nodone", {m1_done, m0_done}, 2'b00);
    rst_n = 1'b1;

    // Both masters requesting continuously: grants alternate, m0 first after reset.
    m0_req = 1'b1; m0_wr = 1'b0; m0_io = 1'b0; m0_addr = 15'h0100;
    m1_req = 1'b1; m1_wr = 1'b1; m1_io = 1'b1; m1_addr = 15'h0200; m1_wdata = 8'h11;
    ndone = 0;
    idle_seen = 1'b0;
    prio = 1'b0;
    for (int cyc = 0; cyc < 200 && ndone < 4; cyc++) begin
      @(negedge clk);
      if (m0_done || m1_done) begin
        exp_m1 = prio;
        prio = !exp_m1;
        chk("rr_order", {m1_done, m0_done}, exp_m1 ? 2'b10 : 2'b01);
        if (ndone > 0) chk("rr_idle_gap", idle_seen, 1'b1);
        ndone++;
        idle_seen = 1'b0;
      end else if (!busy) begin
        idle_seen = 1'b1;
      end
    end
    chk("rr_count", ndone, 4);
    m0_req = 1'b0;
    m1_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
